mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the tagged fetch/load bus that caches use as initiators.
//  It accepts one BUS_LOAD/BUS_STORE per cycle and answers with a nonzero transaction
//  tag on mem2proc_response, or 0 for "not accepted, retry".
//  It returns load data LATENCY cycles later, together with the same tag on mem2proc_tag.
//  It sits between the icache/dcache arbiter and the backing store, and serves as the
//  synthesizable memory model for core-level benches.
// PARAMETERS
//  MEM_WORDS  2048  number of 64-bit words in the backing array (word index = addr[31:3])
//  LATENCY    4     cycles from acceptance edge to data beat; legal range 1..31
//  NUM_TAGS   15    usable tags 1..NUM_TAGS; legal range 1..15; tag 0 is reserved
// PORTS
//  clock              in   1   single clock; all state updates on posedge
//  reset              in   1   asynchronous, active-low (asserted when 0)
//  proc2mem_command   in   2   BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; value 3 is treated as BUS_NONE
//  proc2mem_addr      in   32  byte address; bits [2:0] are ignored
//  proc2mem_data      in   64  store data
//  mem2proc_response  out  4   combinational: allocated tag if accepted this cycle, else 0
//  mem2proc_data      out  64  registered: load data; valid only while mem2proc_tag != 0
//  mem2proc_tag       out  4   registered: tag of the data beat this cycle; 0 = no beat
// BEHAVIOUR
//  Reset
//   - Forces mem2proc_tag = 0 and mem2proc_data = 0.
//   - Marks all tags free and empties the in-flight queue.
//   - mem2proc_response = 0 while reset is asserted.
//   - Backing array contents are NOT cleared.
//   - Reset mid-operation drops every in-flight load; no beat is ever emitted for a dropped tag.
//  Acceptance
//   - A cycle with command LOAD/STORE and at least one free tag is accepted.
//   - mem2proc_response = the lowest-numbered free tag; the initiator samples it at the same posedge (edge E0).
//   - With no free tag, mem2proc_response = 0 and no state changes.
//   - BUS_NONE always yields response 0.
//  Store
//   - Writes proc2mem_data at E0. The tag is returned on response but is never held busy.
//   - No data beat is ever produced for a store.
//   - Word index >= MEM_WORDS: the write is dropped, but the store is still accepted.
//  Load
//   - Reads the array at E0 (snapshot).
//   - A store accepted at an earlier edge is visible to the load; the array is single-ported, one command per cycle.
//   - Out-of-range word index returns 64'hFFFF_FFFF_FFFF_FFFF.
//   - The tag is marked busy at E0. The load enters an in-order queue of depth min(LATENCY, NUM_TAGS), each entry with a countdown.
//  Data beat
//   - Starting at edge E0+LATENCY, mem2proc_tag = tag and mem2proc_data = snapshot for exactly one cycle; both return to 0 at the next edge.
//   - Fixed latency plus at most one acceptance per cycle means at most one beat per cycle, in acceptance order.
//  Tag release
//   - A tag is freed at the edge that ends its beat. It is allocatable from the following cycle, never in the beat cycle itself.
//   - Acceptance and a beat in the same cycle are independent: the new tag is chosen before the release.
//  Tag exhaustion
//   - Occurs only when LATENCY >= NUM_TAGS.
//   - The responder then refuses (response 0) until a release; it never reuses a busy tag.
//  Widths and counters
//   - Countdown counters are 5 bits.
//   - The busy set is a NUM_TAGS-bit vector; the lowest-free search is a priority encoder over it.
// TESTING
//  1. Reset: hold reset=0 with command=LOAD -> response=0, tag=0, data=0. Release reset, LOAD addr 0x0 -> response=1.
//  2. Basic load, LATENCY=4:
//     - Preload word 5 = 64'hDEAD_BEEF_0123_4567.
//     - LOAD addr 0x28 accepted at E0 -> response=1; beat tag=1 with that data for exactly 1 cycle after E0+4.
//  3. Store then load:
//     - STORE addr 0x40 data 64'hA5 at E0 -> response=1.
//     - LOAD 0x40 at E1 -> response=1 (store tag not held); beat after E1+4 carries 64'hA5. No beat ever for the store.
//  4. Back-to-back loads at 4 consecutive edges -> responses 1,2,3,4.
//     - Beats tag 1,2,3,4 on 4 consecutive cycles.
//     - The next load after beat 1 ends gets tag 1.
//  5. Exhaustion (NUM_TAGS=3, LATENCY=6): loads on 5 consecutive cycles -> responses 1,2,3,0,0.
//     - The first retry after tag 1's beat ends -> response=1.
//  6. Reset mid-flight: 2 loads outstanding, pulse reset low for 1 cycle -> no beats are emitted; the next LOAD gets response=1.
//  7. Out of range: LOAD addr 0x4000 (MEM_WORDS=2048) -> beat data 64'hFFFF_FFFF_FFFF_FFFF.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the tagged fetch/load bus. It accepts at most one
//   LOAD or STORE per cycle and returns the lowest free tag on mem2proc_response,
//   or 0 to mean "not accepted, retry". Load data comes back LATENCY cycles
//   later, in acceptance order, as a one-cycle beat on mem2proc_tag/mem2proc_data.
//   Stores write the backing array at once and never hold their tag busy.
//
// Ports
//   clock             : single clock, all state updates on posedge
//   reset             : asynchronous, active-low
//   proc2mem_command  : 0 NONE, 1 LOAD, 2 STORE, 3 treated as NONE
//   proc2mem_addr     : byte address, word index = addr[31:3]
//   proc2mem_data     : store data
//   mem2proc_response : combinational, tag allocated this cycle or 0
//   mem2proc_data     : registered load data, valid while mem2proc_tag != 0
//   mem2proc_tag      : registered tag of this cycle's data beat, 0 = no beat
module mem_responder #(
    parameter int MEM_WORDS = 2048,
    parameter int LATENCY   = 4,
    parameter int NUM_TAGS  = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [31:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);

    // In-flight loads never exceed the latency (one acceptance per cycle)
    // nor the number of tags, so the queue only needs the smaller of the two.
    localparam int QD = (LATENCY < NUM_TAGS) ? LATENCY : NUM_TAGS;
    localparam int PW = (QD > 1) ? $clog2(QD) : 1;
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // Backing store; deliberately outside the reset domain.
    logic [63:0] mem_q [MEM_WORDS];

    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [QD-1:0]       q_vld_q, q_vld_d;
    logic [4:0]          q_cnt_q  [QD];
    logic [4:0]          q_cnt_d  [QD];
    logic [3:0]          q_tag_q  [QD];
    logic [3:0]          q_tag_d  [QD];
    logic [63:0]         q_data_q [QD];
    logic [63:0]         q_data_d [QD];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [3:0]          tag_q, tag_d;
    logic [63:0]         data_q, data_d;

    logic        is_load, is_store, accept, load_acc, store_acc, in_range, pop;
    logic [3:0]  free_tag;
    logic [31:0] word_idx;
    logic [63:0] rd_word;
    logic        unused_addr_bits;

    function automatic logic [3:0] lowest_free(input logic [NUM_TAGS-1:0] busy);
        logic [3:0] r;
        r = 4'd0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (!busy[t]) r = 4'(t + 1);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(QD - 1)) ? '0 : p + PW'(1);
    endfunction

    // ---- decode and acceptance (combinational response) ----
    assign unused_addr_bits = ^proc2mem_addr[2:0];
    assign word_idx  = {3'b000, proc2mem_addr[31:3]};
    assign in_range  = (word_idx < 32'(MEM_WORDS));
    assign rd_word   = in_range ? mem_q[word_idx[AW-1:0]] : '1;

    assign is_load   = (proc2mem_command == 2'd1);
    assign is_store  = (proc2mem_command == 2'd2);
    assign free_tag  = lowest_free(busy_q);
    assign accept    = reset && (is_load || is_store) && (free_tag != 4'd0);
    assign load_acc  = accept && is_load;
    assign store_acc = accept && is_store;

    assign mem2proc_response = accept ? free_tag : 4'd0;

    // Head of the in-order queue leaves when its countdown has expired.
    assign pop = q_vld_q[rd_ptr_q] && (q_cnt_q[rd_ptr_q] == 5'd0);

    // ---- next state: release, countdown, beat, enqueue ----
    always_comb begin
        busy_d   = busy_q;
        q_vld_d  = q_vld_q;
        q_cnt_d  = q_cnt_q;
        q_tag_d  = q_tag_q;
        q_data_d = q_data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        tag_d    = 4'd0;
        data_d   = 64'd0;

        // The tag on the bus this cycle is released at the edge ending its beat.
        for (int t = 0; t < NUM_TAGS; t++) begin
            if (tag_q == 4'(t + 1)) busy_d[t] = 1'b0;
        end

        for (int i = 0; i < QD; i++) begin
            if (q_vld_q[i] && (q_cnt_q[i] != 5'd0)) q_cnt_d[i] = q_cnt_q[i] - 5'd1;
        end

        if (pop) begin
            tag_d             = q_tag_q[rd_ptr_q];
            data_d            = q_data_q[rd_ptr_q];
            q_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = next_ptr(rd_ptr_q);
        end

        // Enqueue after pop: with a full queue the freed slot is reused at once.
        if (load_acc) begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                if (free_tag == 4'(t + 1)) busy_d[t] = 1'b1;
            end
            q_vld_d[wr_ptr_q]  = 1'b1;
            q_cnt_d[wr_ptr_q]  = 5'(LATENCY - 1);
            q_tag_d[wr_ptr_q]  = free_tag;
            q_data_d[wr_ptr_q] = rd_word;
            wr_ptr_d           = next_ptr(wr_ptr_q);
        end
    end

    // ---- control registers ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q   <= '0;
            q_vld_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            tag_q    <= 4'd0;
            data_q   <= 64'd0;
        end else begin
            busy_q   <= busy_d;
            q_vld_q  <= q_vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
        end
    end

    // ---- queue payload, qualified by q_vld_q ----
    always_ff @(posedge clock) begin
        q_cnt_q  <= q_cnt_d;
        q_tag_q  <= q_tag_d;
        q_data_q <= q_data_d;
    end

    // Out-of-range stores are accepted but dropped here.
    always_ff @(posedge clock) begin
        if (store_acc && in_range) mem_q[word_idx[AW-1:0]] <= proc2mem_data;
    end

    assign mem2proc_tag  = tag_q;
    assign mem2proc_data = data_q;

endmodule
